idma_raddr_desc_gen: RTL

Upstream read-address descriptor generator for the iDMA 256-bit read path. It accepts one 2D transfer descriptor: base address, words per row, row count and row stride. It expands the descriptor into a stream of {start address, word count} segments. The segments are presented on the `raddr_fifo_*` interface that the 256b AXI read interface pops, so the block replaces a plain address FIFO with an on-the-fly generator.

---
 rtl/idma_raddr_desc_gen_if.sv | 28 ++
 rtl/idma_raddr_desc_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/idma_raddr_desc_gen_if.sv
// Read-address segment channel between the descriptor generator and the
// 256-bit AXI read interface.
//
// Handshake: a segment is valid while raddr_fifo_empty is 0; it is consumed
// on a clock edge where raddr_fifo_empty is 0 and raddr_fifo_pop is 1. The
// address and word count stay stable until that edge; a pop while empty is 1
// has no effect.
`timescale 1ns/1ps
interface idma_raddr_desc_gen_if;
  logic [31:0] raddr_fifo_raddr_in;
  logic [31:0] raddr_fifo_rd_num_word;
  logic        raddr_fifo_empty;
  logic        raddr_fifo_pop;

  modport master (
    output raddr_fifo_raddr_in,
    output raddr_fifo_rd_num_word,
    output raddr_fifo_empty,
    input  raddr_fifo_pop
  );

  modport slave (
    input  raddr_fifo_raddr_in,
    input  raddr_fifo_rd_num_word,
    input  raddr_fifo_empty,
    output raddr_fifo_pop
  );
endinterface

// File: rtl/idma_raddr_desc_gen.sv
// idma_raddr_desc_gen: expands one 2D read descriptor (base, words per row,
// row count, row stride) into {byte address, word count} segments of at most
// SEG_WORDS 32-byte words, presented on a FIFO-style pop interface.
//
// Optional feature macro: IDMA_RADDR_GEN_2D_EN. When undefined the transfer
// is a single row (cfg_row_num only distinguishes zero from non-zero) and the
// stride/row-count datapath is not built.
`timescale 1ns/1ps
module idma_raddr_desc_gen #(
  parameter int SEG_WORDS = 16,
  parameter int ROWW      = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_start,
  input  logic [31:0]          cfg_base_addr,
  input  logic [31:0]          cfg_row_words,
  input  logic [ROWW-1:0]      cfg_row_num,
  input  logic [31:0]          cfg_row_stride,
  input  logic                 cfg_clear,
  idma_raddr_desc_gen_if.master raddr_fifo,
  output logic                 gen_busy,
  output logic                 gen_done,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] SEG_W = 32'(SEG_WORDS);

  state_e      state_q, state_d;
  logic [31:0] row_addr_q, row_addr_d;
  logic [31:0] row_words_q, row_words_d;
  logic [31:0] word_offset_q, word_offset_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [31:0] out_num_q, out_num_d;
  logic        empty_q, empty_d;

`ifdef IDMA_RADDR_GEN_2D_EN
  logic [ROWW-1:0] row_num_q, row_num_d;
  logic [ROWW-1:0] row_cnt_q, row_cnt_d;
  logic [31:0]     stride_q, stride_d;
  logic            last_row;
  logic            unused_cfg;
  assign last_row   = (row_cnt_q == row_num_q - ROWW'(1));
  assign unused_cfg = ^{cfg_base_addr[4:0], cfg_row_stride[4:0]};
`else
  logic row_nz_q, row_nz_d;
  logic unused_cfg;
  assign unused_cfg = ^{cfg_base_addr[4:0], cfg_row_stride};
`endif

  logic        rows_zero;
  logic        pop_ok;
  logic        load_seg;
  logic [31:0] cur_rem;
  logic [31:0] nxt_rem;

`ifdef IDMA_RADDR_GEN_2D_EN
  assign rows_zero = (row_num_q == '0);
`else
  assign rows_zero = ~row_nz_q;
`endif

  // Words left in the current row from the current offset.
  assign cur_rem = row_words_q - word_offset_q;
  // A presented segment is accepted only in EMIT.
  assign pop_ok  = (state_q == ST_EMIT) && !empty_q && raddr_fifo.raddr_fifo_pop;

  // Next-state and datapath update; the next segment is computed from the
  // updated offset/row address so a pop reloads the output in the same cycle.
  always_comb begin
    state_d       = state_q;
    row_addr_d    = row_addr_q;
    row_words_d   = row_words_q;
    word_offset_d = word_offset_q;
    out_addr_d    = out_addr_q;
    out_num_d     = out_num_q;
    empty_d       = empty_q;
    load_seg      = 1'b0;
    nxt_rem       = '0;
`ifdef IDMA_RADDR_GEN_2D_EN
    row_num_d     = row_num_q;
    row_cnt_d     = row_cnt_q;
    stride_d      = stride_q;
`else
    row_nz_d      = row_nz_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d       = ST_LOAD;
          row_addr_d    = {cfg_base_addr[31:5], 5'b0};
          row_words_d   = cfg_row_words;
          word_offset_d = '0;
`ifdef IDMA_RADDR_GEN_2D_EN
          row_num_d     = cfg_row_num;
          row_cnt_d     = '0;
          stride_d      = {cfg_row_stride[31:5], 5'b0};
`else
          row_nz_d      = (cfg_row_num != '0);
`endif
        end
      end
      ST_LOAD: begin
        if (row_words_q == '0 || rows_zero) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_EMIT;
          load_seg = 1'b1;
        end
      end
      ST_EMIT: begin
        if (pop_ok) begin
          if (cur_rem > SEG_W) begin
            word_offset_d = word_offset_q + SEG_W;
            load_seg      = 1'b1;
          end else begin
            word_offset_d = '0;
`ifdef IDMA_RADDR_GEN_2D_EN
            row_addr_d = row_addr_q + stride_q;
            row_cnt_d  = row_cnt_q + ROWW'(1);
            if (last_row) begin
              state_d = ST_DONE;
              empty_d = 1'b1;
            end else begin
              load_seg = 1'b1;
            end
`else
            state_d = ST_DONE;
            empty_d = 1'b1;
`endif
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (load_seg) begin
      nxt_rem    = row_words_d - word_offset_d;
      out_num_d  = (nxt_rem > SEG_W) ? SEG_W : nxt_rem;
      out_addr_d = row_addr_d + {word_offset_d[26:0], 5'b0};
      empty_d    = 1'b0;
    end

    // Abort wins over everything else in the same cycle.
    if (cfg_clear) begin
      state_d    = ST_IDLE;
      empty_d    = 1'b1;
      out_addr_d = '0;
      out_num_d  = '0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      row_addr_q    <= '0;
      row_words_q   <= '0;
      word_offset_q <= '0;
      out_addr_q    <= '0;
      out_num_q     <= '0;
      empty_q       <= 1'b1;
`ifdef IDMA_RADDR_GEN_2D_EN
      row_num_q     <= '0;
      row_cnt_q     <= '0;
      stride_q      <= '0;
`else
      row_nz_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      row_addr_q    <= row_addr_d;
      row_words_q   <= row_words_d;
      word_offset_q <= word_offset_d;
      out_addr_q    <= out_addr_d;
      out_num_q     <= out_num_d;
      empty_q       <= empty_d;
`ifdef IDMA_RADDR_GEN_2D_EN
      row_num_q     <= row_num_d;
      row_cnt_q     <= row_cnt_d;
      stride_q      <= stride_d;
`else
      row_nz_q      <= row_nz_d;
`endif
    end
  end

  assign raddr_fifo.raddr_fifo_raddr_in    = out_addr_q;
  assign raddr_fifo.raddr_fifo_rd_num_word = out_num_q;
  assign raddr_fifo.raddr_fifo_empty       = empty_q;
  assign gen_busy  = (state_q == ST_LOAD) || (state_q == ST_EMIT);
  assign gen_done  = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule
